// File: rtl/fc_pkg.sv
`default_nettype none
// ---- fc_pkg: shared state type and shift/saturate helper for fc_layer_seq (rev 1.0) ----
package fc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fc_state_t;

   localparam int MAX_ACC_W = 128;

   // Arithmetic shift (floor), clamp to a signed data_w range, optional ReLU.
   function automatic logic signed [MAX_ACC_W-1:0] sat_shift(
      input logic signed [MAX_ACC_W-1:0] sum,
      input int                          frac_w,
      input int                          data_w,
      input logic                        relu
   );
      logic signed [MAX_ACC_W-1:0] one;
      logic signed [MAX_ACC_W-1:0] hi;
      logic signed [MAX_ACC_W-1:0] lo;
      logic signed [MAX_ACC_W-1:0] r;
      one = MAX_ACC_W'(1);
      hi  = (one <<< (data_w - 1)) - one;
      lo  = -(one <<< (data_w - 1));
      r   = sum >>> frac_w;
      if (r > hi)
         r = hi;
      else if (r < lo)
         r = lo;
      if (relu && r[MAX_ACC_W-1])
         r = '0;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fc_mac.sv
`default_nettype none
// ---- fc_mac: signed multiply-accumulate with clear and bias-finalise (rev 1.0) ----
module fc_mac #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int ACC_W  = 40
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     acc_en,
   input  logic                     fin,
   input  logic signed [DATA_W-1:0] w,
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [DATA_W-1:0] bias,
   output logic signed [ACC_W-1:0]  sum
);

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    bias_ext;
   logic signed [ACC_W-1:0]    acc;

   assign prod     = (2*DATA_W)'(w) * (2*DATA_W)'(x);
   assign prod_ext = ACC_W'(prod);
   assign bias_ext = ACC_W'(bias) <<< FRAC_W;
   // Final sum for a node includes the current product, so no extra cycle is spent.
   assign sum      = acc + prod_ext + bias_ext;

   always_ff @(posedge clk) begin
      if (rst || clr)
         acc <= '0;
      else if (acc_en)
         acc <= fin ? '0 : acc + prod_ext;
   end

endmodule
`default_nettype wire

// File: rtl/fc_layer_seq.sv
`default_nettype none
// ---- fc_layer_seq: sequential FC layer, one MAC per clock, streamed weights (rev 1.0) ----
module fc_layer_seq
   import fc_pkg::*;
#(
   parameter  int NUM_IN  = 5,
   parameter  int NUM_OUT = 3,
   parameter  int DATA_W  = 16,
   parameter  int FRAC_W  = 8,
   parameter  int ACC_W   = 40,
   parameter  int RELU_EN = 1,
   localparam int N_W     = NUM_IN * NUM_OUT,
   localparam int ADDR_W  = (N_W > 1) ? $clog2(N_W) : 1,
   localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [NUM_IN*DATA_W-1:0]    in_nodes,
   input  logic [NUM_OUT*DATA_W-1:0]   biases,
   output logic [ADDR_W-1:0]           w_addr,
   output logic                        w_rd_en,
   input  logic [DATA_W-1:0]           w_data,
   output logic                        out_valid,
   output logic [IDX_W-1:0]            out_idx,
   output logic [DATA_W-1:0]           out_data,
   output logic                        busy,
   output logic                        done
);

   localparam int IN_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   fc_state_t state, state_nxt;

   logic [NUM_IN*DATA_W-1:0]  x_lat;
   logic [NUM_OUT*DATA_W-1:0] b_lat;
   logic [IN_W-1:0]           i_a;
   logic [IN_W-1:0]           i_d;
   logic [IDX_W-1:0]          j_a;
   logic [IDX_W-1:0]          j_d;
   logic                      v_d;
   logic                      accept;
   logic                      issue_adv;
   logic                      issue_stop;
   logic                      addr_last;
   logic                      node_last;
   logic                      run_last;
   logic signed [DATA_W-1:0]  x_sel;
   logic signed [DATA_W-1:0]  b_sel;
   logic signed [ACC_W-1:0]   sum;
   logic [DATA_W-1:0]         res;

   assign addr_last = (w_addr == ADDR_W'(N_W - 1));
   assign node_last = v_d && (i_d == IN_W'(NUM_IN - 1));
   assign run_last  = node_last && (j_d == IDX_W'(NUM_OUT - 1));
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)     state_nxt = RUN;
         RUN:     if (addr_last) state_nxt = DRAIN;
         DRAIN:   if (run_last)  state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      accept     = 1'b0;
      issue_adv  = 1'b0;
      issue_stop = 1'b0;
      case (state)
         IDLE:    accept = start;
         RUN: begin
            issue_adv  = !addr_last;
            issue_stop = addr_last;
         end
         default: ;
      endcase
   end

   // Address side: one read per cycle, node/input counters walk j*NUM_IN+i.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_addr  <= '0;
         w_rd_en <= 1'b0;
         i_a     <= '0;
         j_a     <= '0;
      end else if (accept) begin
         w_addr  <= '0;
         w_rd_en <= 1'b1;
         i_a     <= '0;
         j_a     <= '0;
      end else if (issue_adv) begin
         w_addr <= w_addr + 1'b1;
         if (i_a == IN_W'(NUM_IN - 1)) begin
            i_a <= '0;
            j_a <= j_a + 1'b1;
         end else begin
            i_a <= i_a + 1'b1;
         end
      end else if (issue_stop) begin
         w_rd_en <= 1'b0;
      end
   end

   // Return side lags one cycle to match the synchronous memory latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_d <= 1'b0;
         i_d <= '0;
         j_d <= '0;
      end else begin
         v_d <= w_rd_en;
         i_d <= i_a;
         j_d <= j_a;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_lat <= '0;
         b_lat <= '0;
      end else if (accept) begin
         x_lat <= in_nodes;
         b_lat <= biases;
      end
   end

   assign x_sel = x_lat[int'(i_d)*DATA_W +: DATA_W];
   assign b_sel = b_lat[int'(j_d)*DATA_W +: DATA_W];

   fc_mac #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .clr    (accept),
      .acc_en (v_d),
      .fin    (node_last),
      .w      (w_data),
      .x      (x_sel),
      .bias   (b_sel),
      .sum    (sum)
   );

   assign res = DATA_W'(sat_shift(MAX_ACC_W'(sum), FRAC_W, DATA_W, RELU_EN != 0));

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         done      <= 1'b0;
         out_idx   <= '0;
         out_data  <= '0;
      end else begin
         out_valid <= node_last;
         done      <= run_last;
         if (node_last) begin
            out_idx  <= j_d;
            out_data <= res;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_seq.sv
`default_nettype none
// ---- tb_fc_layer_seq: table-driven, scoreboarded bench for fc_layer_seq (rev 1.0) ----
`timescale 1ns/1ps
module tb_fc_layer_seq;

   localparam int NI = 5;
   localparam int NO = 3;
   localparam int DW = 16;

   typedef struct packed {
      logic [15:0]       x;
      logic [15:0]       xs;
      logic [2:0][15:0]  w;
      logic [2:0][15:0]  b;
      logic [2:0][15:0]  el;
      logic [2:0][15:0]  er;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [NI*DW-1:0] in_nodes = '0;
   logic [NO*DW-1:0] biases = '0;
   logic [DW-1:0]    wmem [NI*NO];

   logic [3:0]    wa_l, wa_r;
   logic          re_l, re_r, ov_l, ov_r, bz_l, bz_r, dn_l, dn_r;
   logic [1:0]    oi_l, oi_r;
   logic [DW-1:0] wd_l, wd_r, od_l, od_r;

   logic          start1 = 1'b0;
   logic [DW-1:0] in1 = '0, bias1 = '0, w1 = '0, wd_1;
   logic [0:0]    wa_1, oi_1;
   logic          re_1, ov_1, bz_1, dn_1;
   logic [DW-1:0] od_1;

   int tests = 0;
   int errs = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int nv = 0;
   int nd = 0;
   logic [17:0] q_l [$];
   logic [17:0] q_r [$];
   vec_t tbl [6];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      if (re_l) wd_l <= wmem[wa_l];
      if (re_r) wd_r <= wmem[wa_r];
      if (re_1) wd_1 <= (wa_1 == 1'b0) ? w1 : 16'hDEAD;
   end

   fc_layer_seq #(.NUM_IN(NI), .NUM_OUT(NO), .DATA_W(DW), .FRAC_W(8), .ACC_W(40), .RELU_EN(0)) u_lin (
      .clk(clk), .rst(rst), .start(start), .in_nodes(in_nodes), .biases(biases),
      .w_addr(wa_l), .w_rd_en(re_l), .w_data(wd_l), .out_valid(ov_l), .out_idx(oi_l),
      .out_data(od_l), .busy(bz_l), .done(dn_l));

   fc_layer_seq #(.NUM_IN(NI), .NUM_OUT(NO), .DATA_W(DW), .FRAC_W(8), .ACC_W(40), .RELU_EN(1)) u_relu (
      .clk(clk), .rst(rst), .start(start), .in_nodes(in_nodes), .biases(biases),
      .w_addr(wa_r), .w_rd_en(re_r), .w_data(wd_r), .out_valid(ov_r), .out_idx(oi_r),
      .out_data(od_r), .busy(bz_r), .done(dn_r));

   fc_layer_seq #(.NUM_IN(1), .NUM_OUT(1), .DATA_W(DW), .FRAC_W(8), .ACC_W(40), .RELU_EN(0)) u_one (
      .clk(clk), .rst(rst), .start(start1), .in_nodes(in1), .biases(bias1),
      .w_addr(wa_1), .w_rd_en(re_1), .w_data(wd_1), .out_valid(ov_1), .out_idx(oi_1),
      .out_data(od_1), .busy(bz_1), .done(dn_1));

   function automatic vec_t mk(input logic [15:0] x, xs, input logic [47:0] w, b, el, er);
      vec_t v;
      v.x = x; v.xs = xs; v.w = w; v.b = b; v.el = el; v.er = er;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Called #1 after each rising edge; pops the scoreboard on every result strobe.
   task automatic mon();
      logic [17:0] e;
      if (ov_l) begin
         nv++;
         chk("lin_sb_nonempty", 32'(q_l.size() != 0), 1);
         if (q_l.size() != 0) begin
            e = q_l.pop_front();
            chk("lin_idx", 32'(oi_l), 32'(e[17:16]));
            chk("lin_data", 32'(od_l), 32'(e[15:0]));
            chk("lin_time", cyc - acc_cyc, (int'(e[17:16]) + 1) * NI + 1);
         end
      end
      if (ov_r) begin
         chk("relu_sb_nonempty", 32'(q_r.size() != 0), 1);
         if (q_r.size() != 0) begin
            e = q_r.pop_front();
            chk("relu_idx", 32'(oi_r), 32'(e[17:16]));
            chk("relu_data", 32'(od_r), 32'(e[15:0]));
         end
      end
      if (dn_l) begin
         nd++;
         chk("done_time", cyc - acc_cyc, NI * NO + 1);
         chk("done_with_valid", 32'(ov_l), 1);
         chk("busy_fall", 32'(bz_l), 0);
      end
   endtask

   task automatic load(input int row);
      vec_t v;
      v = tbl[row];
      for (int j = 0; j < NO; j++) begin
         for (int i = 0; i < NI; i++) wmem[j*NI+i] = v.w[j];
         biases[j*DW +: DW] = v.b[j];
         q_l.push_back({2'(j), v.el[j]});
         q_r.push_back({2'(j), v.er[j]});
      end
      for (int i = 0; i < NI; i++) in_nodes[i*DW +: DW] = 16'(v.x + v.xs * 16'(i));
   endtask

   task automatic watch(input int kmax);
      for (int k = 1; k <= kmax && nd == 0; k++) begin
         @(posedge clk); #1;
         mon();
         if (k == NI*NO - 1) chk("addr_last", 32'(wa_l), NI*NO - 1);
         if (k == NI*NO)     chk("rd_off", 32'(re_l), 0);
      end
   endtask

   task automatic accept_edge();
      @(posedge clk); #1;
      acc_cyc = cyc;
      chk("busy_accept", 32'(bz_l), 1);
      chk("addr0", 32'(wa_l), 0);
      chk("rd_en0", 32'(re_l), 1);
   endtask

   task automatic run_vec(input int row);
      load(row);
      nv = 0; nd = 0;
      start = 1'b1;
      accept_edge();
      start = 1'b0;
      in_nodes = '1;
      biases = '1;
      watch(NI*NO + 4);
      chk("valid_count", nv, NO);
      chk("done_count", nd, 1);
      chk("sb_empty", q_l.size() + q_r.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = mk(16'h0100, 16'h0000, {16'hFF00, 16'h0080, 16'h0100}, {16'h0000, 16'h0100, 16'h0000},
                  {16'hFB00, 16'h0380, 16'h0500}, {16'h0000, 16'h0380, 16'h0500});
      tbl[1] = mk(16'h7FFF, 16'h0000, {3{16'h7FFF}}, {3{16'h0000}}, {3{16'h7FFF}}, {3{16'h7FFF}});
      tbl[2] = mk(16'h7FFF, 16'h0000, {3{16'h8000}}, {3{16'h0000}}, {3{16'h8000}}, {3{16'h0000}});
      tbl[3] = mk(16'h0100, 16'h0000, {16'h0000, 16'hFFC0, 16'h0040}, {16'h7FFF, 16'h0080, 16'hFF00},
                  {16'h7FFF, 16'hFF40, 16'h0040}, {16'h7FFF, 16'h0000, 16'h0040});
      tbl[4] = mk(16'h0001, 16'h0000, {16'h0000, 16'h0001, 16'hFFFF}, {16'h8000, 16'h0000, 16'h0000},
                  {16'h8000, 16'h0000, 16'hFFFF}, {16'h0000, 16'h0000, 16'h0000});
      tbl[5] = mk(16'h0100, 16'h0100, {16'h0020, 16'hFF80, 16'h0100}, {16'h0000, 16'h0000, 16'h0000},
                  {16'h01E0, 16'hF880, 16'h0F00}, {16'h01E0, 16'h0000, 16'h0F00});

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bz_l), 0);
      chk("rst_done", 32'(dn_l), 0);
      chk("rst_valid", 32'(ov_l), 0);
      chk("rst_rd_en", 32'(re_l), 0);
      chk("rst_addr", 32'(wa_l), 0);
      chk("rst_idx", 32'(oi_l), 0);
      chk("rst_data", 32'(od_l), 0);
      chk("rst_one_busy", 32'(bz_1), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int r = 0; r < 6; r++) run_vec(r);

      // start held high, dropped and re-raised mid-run, still high in the done cycle
      load(0);
      nv = 0; nd = 0;
      start = 1'b1;
      accept_edge();
      for (int k = 1; k <= NI*NO + 1; k++) begin
         @(posedge clk); #1;
         if (k == 5) start = 1'b0;
         if (k == 7) start = 1'b1;
         mon();
      end
      chk("b2b_valid_count", nv, NO);
      chk("b2b_done_count", nd, 1);
      load(0);
      nv = 0; nd = 0;
      accept_edge();
      start = 1'b0;
      watch(NI*NO + 4);
      chk("b2b2_valid_count", nv, NO);
      chk("b2b2_done_count", nd, 1);
      chk("b2b_sb_empty", q_l.size() + q_r.size(), 0);

      // reset in the middle of a run
      load(3);
      nv = 0; nd = 0;
      start = 1'b1;
      accept_edge();
      start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         mon();
      end
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_busy", 32'(bz_l), 0);
      chk("mid_rst_done", 32'(dn_l), 0);
      chk("mid_rst_valid", 32'(ov_l), 0);
      chk("mid_rst_rd_en", 32'(re_l), 0);
      chk("mid_rst_addr", 32'(wa_l), 0);
      chk("mid_rst_idx", 32'(oi_l), 0);
      chk("mid_rst_data", 32'(od_l), 0);
      q_l.delete();
      q_r.delete();
      rst = 1'b0;
      nv = 0; nd = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         mon();
      end
      chk("mid_rst_no_done", nd, 0);
      chk("mid_rst_no_valid", nv, 0);
      run_vec(3);

      // single-input, single-output instance
      in1 = 16'h0200; bias1 = 16'h0100; w1 = 16'h0300;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      chk("one_addr", 32'(wa_1), 0);
      chk("one_rd_en", 32'(re_1), 1);
      chk("one_busy", 32'(bz_1), 1);
      @(posedge clk); #1;
      chk("one_rd_off", 32'(re_1), 0);
      chk("one_no_valid_early", 32'(ov_1), 0);
      @(posedge clk); #1;
      chk("one_valid", 32'(ov_1), 1);
      chk("one_data", 32'(od_1), 32'h0700);
      chk("one_idx", 32'(oi_1), 0);
      chk("one_done", 32'(dn_1), 1);
      chk("one_busy_fall", 32'(bz_1), 0);
      @(posedge clk); #1;
      chk("one_valid_pulse", 32'(ov_1), 0);
      chk("one_done_pulse", 32'(dn_1), 0);

      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end

endmodule
`default_nettype wire
